mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
// Shares the single unified memory port between the instruction-fetch requester (I) and the
// load/store requester (D) of the MIPS core. Each access is one transaction: request, grant,
// memory handshake, acknowledge. Reads return 64-bit data; writes carry the core's 2-bit
// memwrite size code. A watchdog aborts accesses the memory never completes.
// PARAMETERS
// DW       64  data width of all rdata/wdata buses
// AW       64  address width
// TIMEOUT  15  max BUSY cycles waiting for mready before abort (>=1)
// PORTS
// clk      in   1   clock, rising edge
// reset    in   1   asynchronous, active-high reset
// ireq     in   1   I read request; held until iack
// iadr     in   AW  I address, stable while ireq
// irdata   out  DW  I read data, valid with iack
// iack     out  1   one-cycle I completion pulse
// dreq     in   1   D request; held until dack
// dwe      in   2   D write code: 00 read, 01 word (dwdata[31:0]), 10/11 doubleword
// dadr     in   AW  D address
// dwdata   in   DW  D write data
// drdata   out  DW  D read data, valid with dack (0 for writes)
// dack     out  1   one-cycle D completion pulse
// err      out  1   pulses with iack/dack when the access timed out
// men      out  1   memory enable, high for the whole BUSY state
// mwe      out  2   write code to memory (11 forwarded as 10)
// madr     out  AW  memory address
// mwdata   out  DW  memory write data
// mrdata   in   DW  memory read data, valid with mready
// mready   in   1   memory completion, one cycle, only meaningful while men=1
// BEHAVIOUR
// - Reset: state IDLE; every output 0 (irdata, drdata, men, mwe, madr, mwdata, acks, err).
// - FSM IDLE -> BUSY -> RESP -> IDLE.
// - IDLE: if any req, choose owner (priority below), latch adr/we/wdata, go BUSY; owner
//   recorded in a register.
// - BUSY: men=1, madr/mwe/mwdata from latched values; watchdog counts 1..TIMEOUT.
//   mready -> capture mrdata into owner's rdata reg (0 for writes), go RESP.
//   Count reaches TIMEOUT without mready -> owner's rdata=0, set err flag, go RESP.
// - RESP: owner's ack=1 and err=flag for exactly this cycle; men=0; go IDLE.
// - Latency: req sampled in IDLE at edge 0 -> men from cycle 1 -> mready in cycle N (N>=1)
//   -> ack in cycle N+1. Minimum 2 cycles request-to-ack; back-to-back grants every 3+ cycles.
// - Requester must drop req the edge after ack; req still high in next IDLE = new request.
// - req/adr changes while not owner or while BUSY are ignored (values latched at grant).
// - mready outside BUSY ignored; mready in the same cycle as timeout wins (normal completion).
// - rdata regs hold last value until overwritten; the non-owner's rdata never changes.
// - Reset mid-transaction: immediate return to IDLE, men drops asynchronously, no ack issued.
// - Default priority: fixed, D over I (older instruction in MEM stage must not stall).
// CONFIGURATION
// - MEM_ARB_RR_EN defined: round-robin; on simultaneous ireq&dreq grant the requester not
//   granted last (last-grant reg resets to I, so first tie goes to D). Single requester
//   always granted. Undefined: fixed D-over-I priority, no last-grant register.
// TESTING
// 1 ireq, iadr=0x40, mready 1st BUSY cycle, mrdata=0x20020005 -> iack cycle 2, irdata=0x20020005
// 2 dreq, dwe=01, dadr=100, dwdata=7 -> men with mwe=01 madr=100 mwdata=7; dack, drdata=0
// 3 ireq&dreq same edge, 3 back-to-back pairs -> fixed: D,I,D ; MEM_ARB_RR_EN: D,I,D,I alternate
// 4 dreq read, mready never -> men high 15 cycles, then dack=1 & err=1, drdata=0, IDLE
// 5 reset asserted in 2nd BUSY cycle -> men=0 same cycle, no ack; after release ireq served
// 6 dwe=11 write dadr=508 -> mwe=10 at memory

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates I-fetch and D load/store onto one memory port, with a watchdog abort.
// Optional round-robin arbitration via MEM_ARB_RR_EN (default: fixed D-over-I priority).
`default_nettype none

module mem_arbiter #(
  parameter int DW      = 64,
  parameter int AW      = 64,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ireq,
  input  logic [AW-1:0] iadr,
  output logic [DW-1:0] irdata,
  output logic          iack,
  input  logic          dreq,
  input  logic [1:0]    dwe,
  input  logic [AW-1:0] dadr,
  input  logic [DW-1:0] dwdata,
  output logic [DW-1:0] drdata,
  output logic          dack,
  output logic          err,
  output logic          men,
  output logic [1:0]    mwe,
  output logic [AW-1:0] madr,
  output logic [DW-1:0] mwdata,
  input  logic [DW-1:0] mrdata,
  input  logic          mready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int            c_CW        = $clog2(TIMEOUT + 1);
  localparam logic [c_CW-1:0] c_TO      = c_CW'(TIMEOUT);
  localparam logic [DW-1:0] c_WORD_MASK = DW'({32{1'b1}});

  state_t          r_state;
  logic            r_owner_d;
  logic [c_CW-1:0] r_cnt;

  logic            w_any_req;
  logic            w_grant_d;
  logic [1:0]      w_dwe_fwd;
  logic [DW-1:0]   w_dwdata_fwd;
  logic            w_done;

  assign w_any_req = ireq | dreq;

`ifdef MEM_ARB_RR_EN
  // Last-grant register: 1 = D was granted last. Resets to I so the first tie goes to D.
  logic r_last_d;
  assign w_grant_d = dreq & (~ireq | ~r_last_d);
`else
  assign w_grant_d = dreq;
`endif

  // Doubleword code 11 is presented to memory as 10; word writes only carry the low 32 bits.
  assign w_dwe_fwd    = (dwe == 2'b11) ? 2'b10 : dwe;
  assign w_dwdata_fwd = (dwe == 2'b00) ? '0 :
                        (dwe == 2'b01) ? (dwdata & c_WORD_MASK) : dwdata;

  // Completion beats the watchdog when both land in the same cycle.
  assign w_done = mready | (r_cnt == c_TO);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_owner_d <= 1'b0;
      r_cnt     <= '0;
      irdata    <= '0;
      drdata    <= '0;
      iack      <= 1'b0;
      dack      <= 1'b0;
      err       <= 1'b0;
      men       <= 1'b0;
      mwe       <= 2'b00;
      madr      <= '0;
      mwdata    <= '0;
`ifdef MEM_ARB_RR_EN
      r_last_d  <= 1'b0;
`endif
    end else begin
      iack <= 1'b0;
      dack <= 1'b0;
      err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner_d <= w_grant_d;
            r_cnt     <= c_CW'(1);
            men       <= 1'b1;
            r_state   <= S_BUSY;
            if (w_grant_d) begin
              madr   <= dadr;
              mwe    <= w_dwe_fwd;
              mwdata <= w_dwdata_fwd;
            end else begin
              madr   <= iadr;
              mwe    <= 2'b00;
              mwdata <= '0;
            end
`ifdef MEM_ARB_RR_EN
            r_last_d <= w_grant_d;
`endif
          end
        end
        S_BUSY: begin
          if (w_done) begin
            men     <= 1'b0;
            err     <= ~mready;
            r_state <= S_RESP;
            if (r_owner_d) begin
              dack   <= 1'b1;
              drdata <= (mready && mwe == 2'b00) ? mrdata : '0;
            end else begin
              iack   <= 1'b1;
              irdata <= mready ? mrdata : '0;
            end
          end else begin
            r_cnt <= r_cnt + c_CW'(1);
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
`default_nettype none

module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq;
  logic [63:0] iadr;
  logic [63:0] irdata;
  logic        iack;
  logic        dreq;
  logic [1:0]  dwe;
  logic [63:0] dadr;
  logic [63:0] dwdata;
  logic [63:0] drdata;
  logic        dack;
  logic        err;
  logic        men;
  logic [1:0]  mwe;
  logic [63:0] madr;
  logic [63:0] mwdata;
  logic [63:0] mrdata;
  logic        mready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DW(64), .AW(64), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .ireq(ireq), .iadr(iadr), .irdata(irdata), .iack(iack),
    .dreq(dreq), .dwe(dwe), .dadr(dadr), .dwdata(dwdata), .drdata(drdata), .dack(dack),
    .err(err), .men(men), .mwe(mwe), .madr(madr), .mwdata(mwdata),
    .mrdata(mrdata), .mready(mready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Called in the first BUSY cycle of a read: checks address, completes it, checks the ack.
  task automatic serve(input string tag, input logic exp_d, input logic [63:0] exp_adr,
                       input logic [63:0] data);
    chk({tag, "_adr"}, madr, exp_adr);
    mready = 1'b1;
    mrdata = data;
    step();
    mready = 1'b0;
    mrdata = 64'h0;
    chkb({tag, "_dack"}, dack, exp_d);
    chkb({tag, "_iack"}, iack, ~exp_d);
    chk({tag, "_rdata"}, exp_d ? drdata : irdata, data);
    if (exp_d) dreq = 1'b0;
    else       ireq = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1; ireq = 1'b0; iadr = 64'h0; dreq = 1'b0; dwe = 2'b00;
    dadr = 64'h0; dwdata = 64'h0; mrdata = 64'h0; mready = 1'b0;
    step();
    step();
    chkb("rst_men", men, 1'b0);
    chk("rst_mwe", 64'(mwe), 64'h0);
    chk("rst_madr", madr, 64'h0);
    chk("rst_mwdata", mwdata, 64'h0);
    chkb("rst_iack", iack, 1'b0);
    chkb("rst_dack", dack, 1'b0);
    chkb("rst_err", err, 1'b0);
    chk("rst_irdata", irdata, 64'h0);
    chk("rst_drdata", drdata, 64'h0);
    reset = 1'b0;
    step();

    // I read, memory answers in the first BUSY cycle
    ireq = 1'b1; iadr = 64'h40;
    step();
    chkb("t1_men", men, 1'b1);
    chk("t1_madr", madr, 64'h40);
    chk("t1_mwe", 64'(mwe), 64'h0);
    chkb("t1_early_iack", iack, 1'b0);
    mready = 1'b1; mrdata = 64'h20020005;
    step();
    mready = 1'b0; mrdata = 64'h0;
    chkb("t1_iack", iack, 1'b1);
    chk("t1_irdata", irdata, 64'h20020005);
    chkb("t1_err", err, 1'b0);
    chkb("t1_dack", dack, 1'b0);
    chkb("t1_men_resp", men, 1'b0);
    ireq = 1'b0;
    step();
    chkb("t1_iack_drop", iack, 1'b0);

    // stray mready while idle must not produce anything
    mready = 1'b1; mrdata = 64'hDEAD;
    step();
    mready = 1'b0; mrdata = 64'h0;
    chkb("idle_mready_men", men, 1'b0);
    chkb("idle_mready_iack", iack, 1'b0);
    chkb("idle_mready_dack", dack, 1'b0);

    // D word write, completed in second BUSY cycle
    dreq = 1'b1; dwe = 2'b01; dadr = 64'd100; dwdata = 64'd7;
    step();
    chkb("t2_men", men, 1'b1);
    chk("t2_mwe", 64'(mwe), 64'h1);
    chk("t2_madr", madr, 64'd100);
    chk("t2_mwdata", mwdata, 64'd7);
    step();
    chkb("t2_men2", men, 1'b1);
    chkb("t2_dack_early", dack, 1'b0);
    mready = 1'b1; mrdata = 64'hFFFF;
    step();
    mready = 1'b0; mrdata = 64'h0;
    chkb("t2_dack", dack, 1'b1);
    chk("t2_drdata", drdata, 64'h0);
    chkb("t2_iack", iack, 1'b0);
    chkb("t2_err", err, 1'b0);
    chk("t2_irdata_hold", irdata, 64'h20020005);
    dreq = 1'b0; dwe = 2'b00;
    step();

    // simultaneous requests: D first, then I
    ireq = 1'b1; iadr = 64'h80; dreq = 1'b1; dadr = 64'h200;
    step();
    serve("t3a_d", 1'b1, 64'h200, 64'hA1);
    chkb("t3a_idle_men", men, 1'b0);
    step();
    serve("t3a_i", 1'b0, 64'h80, 64'hB1);
    ireq = 1'b1; iadr = 64'h88; dreq = 1'b1; dadr = 64'h208;
    step();
    serve("t3b_d", 1'b1, 64'h208, 64'hA2);
    step();
    serve("t3b_i", 1'b0, 64'h88, 64'hB2);
    dreq = 1'b1; dadr = 64'h210;
    step();
    serve("t3c_d", 1'b1, 64'h210, 64'hA3);
    ireq = 1'b1; iadr = 64'h8C; dreq = 1'b1; dadr = 64'h220;
    step();
`ifdef MEM_ARB_RR_EN
    serve("t3d_i", 1'b0, 64'h8C, 64'hB4);
    step();
    serve("t3d_d", 1'b1, 64'h220, 64'hA4);
`else
    serve("t3d_d", 1'b1, 64'h220, 64'hA4);
    step();
    serve("t3d_i", 1'b0, 64'h8C, 64'hB4);
`endif

    // watchdog: men held exactly TIMEOUT cycles, then ack with err and zero data
    dreq = 1'b1; dwe = 2'b00; dadr = 64'h300;
    step();
    for (int i = 1; i <= 15; i++) begin
      chkb($sformatf("t4_men_c%0d", i), men, 1'b1);
      chkb($sformatf("t4_dack_c%0d", i), dack, 1'b0);
      step();
    end
    chkb("t4_dack", dack, 1'b1);
    chkb("t4_err", err, 1'b1);
    chk("t4_drdata", drdata, 64'h0);
    chkb("t4_men", men, 1'b0);
    dreq = 1'b0;
    step();
    chkb("t4_dack_drop", dack, 1'b0);
    chkb("t4_err_drop", err, 1'b0);

    // mready in the timeout cycle wins
    dreq = 1'b1; dadr = 64'h308;
    step();
    for (int i = 1; i <= 14; i++) step();
    chkb("t4b_men_c15", men, 1'b1);
    mready = 1'b1; mrdata = 64'h5555;
    step();
    mready = 1'b0; mrdata = 64'h0;
    chkb("t4b_dack", dack, 1'b1);
    chkb("t4b_err", err, 1'b0);
    chk("t4b_drdata", drdata, 64'h5555);
    dreq = 1'b0;
    step();

    // reset in the second BUSY cycle
    ireq = 1'b1; iadr = 64'h44;
    step();
    step();
    chkb("t5_men_busy", men, 1'b1);
    reset = 1'b1;
    #1;
    chkb("t5_men_async", men, 1'b0);
    chkb("t5_iack", iack, 1'b0);
    chk("t5_irdata_rst", irdata, 64'h0);
    step();
    chkb("t5_men_held", men, 1'b0);
    chkb("t5_iack_held", iack, 1'b0);
    reset = 1'b0;
    step();
    chkb("t5_men_regrant", men, 1'b1);
    serve("t5_i", 1'b0, 64'h44, 64'h77);

    // doubleword code 11 forwarded as 10
    dreq = 1'b1; dwe = 2'b11; dadr = 64'd508; dwdata = 64'h1122334455667788;
    step();
    chk("t6_mwe", 64'(mwe), 64'h2);
    chk("t6_madr", madr, 64'd508);
    chk("t6_mwdata", mwdata, 64'h1122334455667788);
    mready = 1'b1; mrdata = 64'h99;
    step();
    mready = 1'b0; mrdata = 64'h0;
    chkb("t6_dack", dack, 1'b1);
    chk("t6_drdata", drdata, 64'h0);
    dreq = 1'b0; dwe = 2'b00;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
